// File: rtl/tdc_pkg.sv
// Shared types and default sizes for the TDC shot sequencer and its encoder.
package tdc_pkg;

    localparam int unsigned TAPS        = 32;
    localparam int unsigned CNT_W       = $clog2(TAPS + 1);
    localparam int unsigned SHOT_W      = 8;
    localparam int unsigned SUM_W       = CNT_W + SHOT_W;
    localparam int unsigned PULSE_W_DEF = 2;
    localparam int unsigned SETTLE_DEF  = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_LATCH   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_ACCUM   = 3'd5,
        ST_DONE    = 3'd6
    } tdc_state_e;

    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic [CNT_W-1:0] min_cnt;
        logic [CNT_W-1:0] max_cnt;
        logic             bubble;
        logic             ovf;
    } tdc_result_t;

    // Empty-result value: min starts at all-ones so the first shot always replaces it.
    localparam tdc_result_t RESULT_RST = '{sum: '0, min_cnt: '1, max_cnt: '0,
                                           bubble: 1'b0, ovf: 1'b0};

endpackage

// File: rtl/tdc_therm_encode.sv
// Thermometer decoder: tap count, bubble detect and all-ones detect.
module tdc_therm_encode
    import tdc_pkg::*;
(
    input  logic [TAPS-1:0]  taps,
    output logic [CNT_W-1:0] count_c,
    output logic             bubble_c,
    output logic             ovf_c
);

    // Population count of the sampled taps.
    always_comb begin
        count_c = '0;
        for (int i = 0; i < TAPS; i++) begin
            count_c = count_c + CNT_W'(taps[i]);
        end
    end

    // A set tap above a clear tap breaks the thermometer code.
    assign bubble_c = |(taps[TAPS-1:1] & ~taps[TAPS-2:0]);
    assign ovf_c    = &taps;

endmodule

// File: rtl/tdc_shot_sequencer.sv
// Launch/settle/latch/capture sequencer for the carry-chain TDC with per-measurement
// accumulation of tap counts and a valid/ready result port.
module tdc_shot_sequencer
    import tdc_pkg::*;
#(
    parameter int unsigned PULSE_W = PULSE_W_DEF,
    parameter int unsigned SETTLE  = SETTLE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [SHOT_W-1:0] cfg_shots,
    output logic              busy,
    output logic              pulse,
    output logic              latch,
    input  logic [TAPS-1:0]   taps,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [SUM_W-1:0]  res_sum,
    output logic [CNT_W-1:0]  res_min,
    output logic [CNT_W-1:0]  res_max,
    output logic              res_bubble,
    output logic              res_ovf
);

    localparam int unsigned CYC_MAX = (PULSE_W > SETTLE) ? PULSE_W : SETTLE;
    localparam int unsigned CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

    tdc_state_e        state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [SHOT_W-1:0] shots_q, shots_d;
    logic [TAPS-1:0]   taps_q, taps_d;
    tdc_result_t       acc_q, acc_d;
    tdc_result_t       res_q, res_d;
    tdc_result_t       acc_upd_c;
    logic              busy_q, busy_d;
    logic              pulse_q, pulse_d;
    logic              latch_q, latch_d;
    logic              valid_q, valid_d;

    logic [CNT_W-1:0]  enc_count_c;
    logic              enc_bubble_c;
    logic              enc_ovf_c;

    tdc_therm_encode u_encode (
        .taps     (taps_q),
        .count_c  (enc_count_c),
        .bubble_c (enc_bubble_c),
        .ovf_c    (enc_ovf_c)
    );

    // Running accumulator with the current shot folded in.
    always_comb begin
        acc_upd_c         = acc_q;
        acc_upd_c.sum     = acc_q.sum + SUM_W'(enc_count_c);
        acc_upd_c.min_cnt = (enc_count_c < acc_q.min_cnt) ? enc_count_c : acc_q.min_cnt;
        acc_upd_c.max_cnt = (enc_count_c > acc_q.max_cnt) ? enc_count_c : acc_q.max_cnt;
        acc_upd_c.bubble  = acc_q.bubble | enc_bubble_c;
        acc_upd_c.ovf     = acc_q.ovf | enc_ovf_c;
    end

    // Next-state, counters, accumulators and registered-output next values.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        shots_d = shots_q;
        taps_d  = taps_q;
        acc_d   = acc_q;
        res_d   = res_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_LAUNCH;
                    cyc_d   = '0;
                    shots_d = (cfg_shots == '0) ? SHOT_W'(1) : cfg_shots;
                    acc_d   = RESULT_RST;
                end
            end
            ST_LAUNCH: begin
                if (cyc_q == CYC_W'(PULSE_W - 1)) begin
                    state_d = ST_SETTLE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cyc_q == CYC_W'(SETTLE - 1)) begin
                    state_d = ST_LATCH;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_LATCH: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                taps_d  = taps;
                state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                acc_d   = acc_upd_c;
                shots_d = shots_q - SHOT_W'(1);
                if (shots_q == SHOT_W'(1)) begin
                    state_d = ST_DONE;
                    res_d   = acc_upd_c;
                end else begin
                    state_d = ST_LAUNCH;
                    cyc_d   = '0;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort cancels any measurement in flight; its partial result is never published.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end

        busy_d  = (state_d != ST_IDLE);
        pulse_d = (state_d == ST_LAUNCH);
        latch_d = (state_d == ST_LATCH);
        valid_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            shots_q <= '0;
            taps_q  <= '0;
            acc_q   <= RESULT_RST;
            res_q   <= RESULT_RST;
            busy_q  <= 1'b0;
            pulse_q <= 1'b0;
            latch_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            shots_q <= shots_d;
            taps_q  <= taps_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            pulse_q <= pulse_d;
            latch_q <= latch_d;
            valid_q <= valid_d;
        end
    end

    assign busy       = busy_q;
    assign pulse      = pulse_q;
    assign latch      = latch_q;
    assign res_valid  = valid_q;
    assign res_sum    = res_q.sum;
    assign res_min    = res_q.min_cnt;
    assign res_max    = res_q.max_cnt;
    assign res_bubble = res_q.bubble;
    assign res_ovf    = res_q.ovf;

endmodule

// File: tb/tb_tdc_shot_sequencer.sv
// Directed + randomized bench for tdc_shot_sequencer with a shot-list reference model.
module tb_tdc_shot_sequencer;

    localparam int SHOT_CYC = 2 + 3 + 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  cfg_shots;
    logic        busy;
    logic        pulse;
    logic        latch;
    logic [31:0] taps;
    logic        res_valid;
    logic        res_ready;
    logic [13:0] res_sum;
    logic [5:0]  res_min;
    logic [5:0]  res_max;
    logic        res_bubble;
    logic        res_ovf;

    int n_pass   = 0;
    int n_checks = 0;

    typedef struct {
        int sum;
        int mn;
        int mx;
        bit bub;
        bit ovf;
    } exp_t;

    exp_t cur_exp;

    tdc_shot_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cfg_shots  (cfg_shots),
        .busy       (busy),
        .pulse      (pulse),
        .latch      (latch),
        .taps       (taps),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_min    (res_min),
        .res_max    (res_max),
        .res_bubble (res_bubble),
        .res_ovf    (res_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected result of a measurement from its list of per-shot tap words.
    function automatic exp_t model(input logic [31:0] w[$]);
        exp_t r;
        r.sum = 0;
        r.mn  = 0;
        r.mx  = 0;
        r.bub = 1'b0;
        r.ovf = 1'b0;
        foreach (w[i]) begin
            int c;
            c = $countones(w[i]);
            r.sum += c;
            if (i == 0 || c < r.mn) r.mn = c;
            if (i == 0 || c > r.mx) r.mx = c;
            if ((w[i] & (w[i] + 32'd1)) != 32'd0) r.bub = 1'b1;
            if (w[i] == 32'hFFFF_FFFF) r.ovf = 1'b1;
        end
        return r;
    endfunction

    task automatic check_result(input string name);
        check({name, " res_valid"},  32'(res_valid),  32'd1);
        check({name, " res_sum"},    32'(res_sum),    32'(cur_exp.sum));
        check({name, " res_min"},    32'(res_min),    32'(cur_exp.mn));
        check({name, " res_max"},    32'(res_max),    32'(cur_exp.mx));
        check({name, " res_bubble"}, 32'(res_bubble), 32'(cur_exp.bub));
        check({name, " res_ovf"},    32'(res_ovf),    32'(cur_exp.ovf));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " busy"},       32'(busy),       32'd0);
        check({name, " pulse"},      32'(pulse),      32'd0);
        check({name, " latch"},      32'(latch),      32'd0);
        check({name, " res_valid"},  32'(res_valid),  32'd0);
        check({name, " res_sum"},    32'(res_sum),    32'd0);
        check({name, " res_min"},    32'(res_min),    32'h3F);
        check({name, " res_max"},    32'(res_max),    32'd0);
        check({name, " res_bubble"}, 32'(res_bubble), 32'd0);
        check({name, " res_ovf"},    32'(res_ovf),    32'd0);
    endtask

    // Starts a measurement and walks it cycle by cycle. Returns in the first res_valid
    // cycle, or right after an abort / reset injected at cycle abort_at / rst_at.
    task automatic run_meas(input string name, input int cfg, input logic [31:0] w[$],
                            input int abort_at, input int rst_at, input bit noise);
        int n;
        int last;
        n    = (cfg == 0) ? 1 : cfg;
        last = n * SHOT_CYC + 1;
        if (abort_at == 0 && rst_at == 0) cur_exp = model(w);
        cfg_shots = 8'(cfg);
        taps      = w[0];
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= last; c++) begin
            int idx;
            int ph;
            idx = (c - 1) / SHOT_CYC;
            ph  = (c - 1) % SHOT_CYC;
            if (idx < n) taps = w[idx];
            if (noise) begin
                cfg_shots = 8'($urandom);
                start     = (c < last) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            check({name, " pulse"},     32'(pulse),     32'((c < last) && (ph < 2)));
            check({name, " latch"},     32'(latch),     32'((c < last) && (ph == 5)));
            check({name, " busy"},      32'(busy),      32'd1);
            check({name, " res_valid"}, 32'(res_valid), 32'(c == last));
            if (c == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check({name, " abort busy"},  32'(busy),      32'd0);
                check({name, " abort pulse"}, 32'(pulse),     32'd0);
                check({name, " abort latch"}, 32'(latch),     32'd0);
                check({name, " abort valid"}, 32'(res_valid), 32'd0);
                return;
            end
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs({name, " async rst"});
                tick();
                rst_n = 1'b1;
                tick();
                check({name, " post-rst busy"},  32'(busy),  32'd0);
                check({name, " post-rst pulse"}, 32'(pulse), 32'd0);
                return;
            end
            if (c < last) tick();
        end
        start = 1'b0;
        check_result(name);
    endtask

    // Completes the handshake; optionally drives start in the same cycle (must be ignored).
    task automatic handshake(input string name, input bit with_start);
        res_ready = 1'b1;
        start     = with_start;
        tick();
        res_ready = 1'b0;
        start     = 1'b0;
        check({name, " hs busy"},  32'(busy),      32'd0);
        check({name, " hs valid"}, 32'(res_valid), 32'd0);
        tick();
        check({name, " idle busy"},  32'(busy),  32'd0);
        check({name, " idle pulse"}, 32'(pulse), 32'd0);
    endtask

    initial begin
        logic [31:0] w[$];

        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_shots = 8'd1;
        taps      = 32'd0;
        res_ready = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // 1: single shot, eight taps
        w = '{32'h0000_00FF};
        run_meas("t1", 1, w, 0, 0, 1'b0);
        handshake("t1", 1'b0);

        // 2: four shots
        w = '{32'h0000_000F, 32'h0000_00FF, 32'h0000_0003, 32'h0000_003F};
        run_meas("t2", 4, w, 0, 0, 1'b0);
        handshake("t2", 1'b0);

        // 3: zero shots configured runs one shot; all-ones overflows
        w = '{32'hFFFF_FFFF};
        run_meas("t3", 0, w, 0, 0, 1'b0);
        handshake("t3", 1'b0);

        // 4: bubble on one of three shots, then backpressure with stray starts
        w = '{32'h0000_000F, 32'h0000_00F7, 32'h0000_0003};
        run_meas("t4", 3, w, 0, 0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            start     = 1'($urandom_range(0, 1));
            cfg_shots = 8'($urandom);
            tick();
            check_result("t4 hold");
        end
        start = 1'b0;
        handshake("t4", 1'b1);

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("idle abort busy", 32'(busy), 32'd0);
        tick();
        check("idle abort pulse", 32'(pulse), 32'd0);

        // 5: abort in cycle 4 of shot 2, then a clean one-shot measurement
        w = '{32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF};
        run_meas("t5 abort", 3, w, SHOT_CYC + 4, 0, 1'b0);
        tick();
        w = '{32'h0000_0001};
        run_meas("t5 rerun", 1, w, 0, 0, 1'b0);
        handshake("t5", 1'b0);

        // 6: async reset while latch is high
        w = '{32'h0000_0FFF, 32'h0000_0FFF};
        run_meas("t6", 2, w, 0, 6, 1'b0);
        w = '{32'h0000_0007};
        run_meas("t6 rerun", 1, w, 0, 0, 1'b0);
        handshake("t6", 1'b0);

        // randomized measurements with noisy start/cfg_shots while busy
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 5);
            w = {};
            for (int s = 0; s < n; s++) begin
                logic [32:0] m;
                if ($urandom_range(0, 3) == 0) begin
                    w.push_back($urandom);
                end else begin
                    m = (33'd1 << $urandom_range(0, 32)) - 33'd1;
                    w.push_back(m[31:0]);
                end
            end
            run_meas("rand", n, w, 0, 0, 1'b1);
            handshake("rand", 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so a stuck DUT cannot hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
